// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register countdown scoreboard of in-flight writes.
// Holds the instruction in ID (PC hold, IF/ID hold, control bubble) until its sources are ready.
module hazard_scoreboard #(
  parameter int ALU_LAT  = 3,
  parameter int LOAD_LAT = 3,
  parameter int CNT_W    = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] Instruction,
  input  logic        IdValid,
  input  logic        Flush,
  output logic        PCStop,
  output logic        IFIDWrite,
  output logic        ControlMux,
  output logic [31:0] PendingMask,
  output logic [15:0] StallCount
);

  localparam logic [CNT_W-1:0] ALU_INIT  = CNT_W'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LAT - 1);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = Instruction[31:26];
  assign rs    = Instruction[25:21];
  assign rt    = Instruction[20:16];
  assign rd    = Instruction[15:11];
  assign funct = Instruction[5:0];

  // Shift amount field never takes part in hazard decisions.
  logic unused_shamt;
  assign unused_shamt = ^Instruction[10:6];

  logic       reads_rs;
  logic       reads_rt;
  logic       writes;
  logic       is_load;
  logic [4:0] dest;

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    is_load  = 1'b0;
    dest     = rd;
    case (op)
      6'b000000: begin
        if (funct == 6'b001000) begin
          reads_rs = 1'b1;
        end else if (funct == 6'b000000 || funct == 6'b000010 || funct == 6'b000011) begin
          reads_rt = 1'b1;
          writes   = 1'b1;
        end else begin
          reads_rs = 1'b1;
          reads_rt = 1'b1;
          writes   = 1'b1;
        end
      end
      6'b011100: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
        writes   = 1'b1;
      end
      6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b001010, 6'b001011: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        dest     = rt;
      end
      6'b001111: begin
        writes = 1'b1;
        dest   = rt;
      end
      6'b100000, 6'b100001, 6'b100011: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        is_load  = 1'b1;
        dest     = rt;
      end
      6'b101000, 6'b101001, 6'b101011,
      6'b000100, 6'b000101: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      6'b000001, 6'b000110, 6'b000111: begin
        reads_rs = 1'b1;
      end
      6'b000011: begin
        writes = 1'b1;
        dest   = 5'd31;
      end
      default: begin
        writes = 1'b0;
      end
    endcase
  end

  // cnt[0] is held at zero so $0 can never stall a reader.
  logic [CNT_W-1:0] cnt      [32];
  logic [CNT_W-1:0] cnt_next [32];
  logic             hazard;
  logic             issue;
  logic [CNT_W-1:0] issue_init;

  assign hazard = IdValid && !Flush &&
                  ((reads_rs && cnt[rs] != '0) || (reads_rt && cnt[rt] != '0));
  assign issue      = IdValid && !Flush && !hazard && writes && (dest != 5'd0);
  assign issue_init = is_load ? LOAD_INIT : ALU_INIT;

  assign PCStop     = hazard;
  assign IFIDWrite  = !hazard;
  assign ControlMux = hazard;

  always_comb begin
    logic [CNT_W-1:0] dec;
    dec = '0;
    for (int r = 0; r < 32; r++) begin
      dec         = (cnt[r] != '0) ? cnt[r] - CNT_W'(1) : '0;
      cnt_next[r] = dec;
      // Keep the larger count so a younger short write never hides an older long one.
      if (issue && dest == 5'(r) && issue_init > dec) begin
        cnt_next[r] = issue_init;
      end
      if (r == 0) begin
        cnt_next[r] = '0;
      end
    end
  end

  always_comb begin
    PendingMask = '0;
    for (int r = 0; r < 32; r++) begin
      PendingMask[r] = (cnt[r] != '0);
    end
  end

  always_ff @(posedge Clk) begin
    for (int r = 0; r < 32; r++) begin
      if (!Rst_n) begin
        cnt[r] <= '0;
      end else begin
        cnt[r] <= cnt_next[r];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      StallCount <= '0;
    end else if (hazard && StallCount != 16'hFFFF) begin
      StallCount <= StallCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed-vector bench for hazard_scoreboard: three instances (default latencies,
// forwarding 1/2, and 1/3 for the WAW case), expected responses checked by a monitor.
module tb_hazard_scoreboard;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [2:0]  rst_n = 3'b000;
  logic [2:0]  idv   = 3'b000;
  logic [2:0]  flush = 3'b000;
  logic [31:0] instr [3];
  logic [2:0]  pc_stop;
  logic [2:0]  ifid_wr;
  logic [2:0]  ctl_mux;
  logic [31:0] mask  [3];
  logic [15:0] scnt  [3];

  initial begin
    for (int i = 0; i < 3; i++) instr[i] = 32'd0;
  end

  hazard_scoreboard u0 (
    .Clk(Clk), .Rst_n(rst_n[0]), .Instruction(instr[0]), .IdValid(idv[0]), .Flush(flush[0]),
    .PCStop(pc_stop[0]), .IFIDWrite(ifid_wr[0]), .ControlMux(ctl_mux[0]),
    .PendingMask(mask[0]), .StallCount(scnt[0])
  );

  hazard_scoreboard #(.ALU_LAT(1), .LOAD_LAT(2), .CNT_W(2)) u1 (
    .Clk(Clk), .Rst_n(rst_n[1]), .Instruction(instr[1]), .IdValid(idv[1]), .Flush(flush[1]),
    .PCStop(pc_stop[1]), .IFIDWrite(ifid_wr[1]), .ControlMux(ctl_mux[1]),
    .PendingMask(mask[1]), .StallCount(scnt[1])
  );

  hazard_scoreboard #(.ALU_LAT(1), .LOAD_LAT(3), .CNT_W(2)) u2 (
    .Clk(Clk), .Rst_n(rst_n[2]), .Instruction(instr[2]), .IdValid(idv[2]), .Flush(flush[2]),
    .PCStop(pc_stop[2]), .IFIDWrite(ifid_wr[2]), .ControlMux(ctl_mux[2]),
    .PendingMask(mask[2]), .StallCount(scnt[2])
  );

  localparam int W = 51;
  logic [W-1:0] exp_q [$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic logic [31:0] r_op(input logic [5:0] funct, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Driver: one vector per cycle, applied just after the rising edge.
  task automatic apply(input int sel, input logic rst, input logic [31:0] ins,
                       input logic v, input logic f, input logic e_stall,
                       input logic [31:0] e_mask, input logic [15:0] e_sc);
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b1;
      idv[i]   = 1'b0;
      flush[i] = 1'b0;
    end
    rst_n[sel] = rst;
    instr[sel] = ins;
    idv[sel]   = v;
    flush[sel] = f;
    exp_q.push_back({2'(sel), e_stall, e_mask, e_sc});
  endtask

  // Monitor: outputs of the addressed instance are sampled mid-cycle.
  logic [W-1:0] e_cur;
  logic [1:0]   s;
  logic [50:0]  act;
  logic [50:0]  want;
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      e_cur = exp_q.pop_front();
      s     = e_cur[50:49];
      act   = {pc_stop[s], ifid_wr[s], ctl_mux[s], mask[s], scnt[s]};
      want  = {e_cur[48], !e_cur[48], e_cur[48], e_cur[47:16], e_cur[15:0]};
      n_vec++;
      if (act !== want) begin
        n_miss++;
        $display("FAIL vec%0d dut%0d: got stall/ifid/mux=%b mask=%h cnt=%0d, want stall/ifid/mux=%b mask=%h cnt=%0d",
                 n_vec, s, act[50:48], act[47:16], act[15:0], want[50:48], want[47:16], want[15:0]);
      end
    end
  end

  logic [31:0] add3, sub4, add5, addi5, sw5, add0, or7, beq3, lw8, add10, addi11, lw4, add4;

  initial begin
    add3   = r_op(6'b100000, 5'd1, 5'd2, 5'd3);
    sub4   = r_op(6'b100010, 5'd3, 5'd5, 5'd4);
    add5   = r_op(6'b100000, 5'd1, 5'd2, 5'd5);
    addi5  = i_op(6'b001000, 5'd6, 5'd5, 16'd4);
    sw5    = i_op(6'b101011, 5'd6, 5'd5, 16'd0);
    add0   = r_op(6'b100000, 5'd1, 5'd2, 5'd0);
    or7    = r_op(6'b100101, 5'd0, 5'd0, 5'd7);
    beq3   = i_op(6'b000100, 5'd3, 5'd3, 16'd8);
    lw8    = i_op(6'b100011, 5'd9, 5'd8, 16'd0);
    add10  = r_op(6'b100000, 5'd8, 5'd8, 5'd10);
    addi11 = i_op(6'b001000, 5'd10, 5'd11, 16'd1);
    lw4    = i_op(6'b100011, 5'd9, 5'd4, 16'd0);
    add4   = r_op(6'b100000, 5'd1, 5'd2, 5'd4);

    // Default latencies: reset, RAW, false-rt, $0, flush, reset mid-stall.
    apply(0, 1'b0, add3,  1'b1, 1'b0, 1'b0, 32'h0,   16'd0);
    apply(0, 1'b0, add3,  1'b1, 1'b0, 1'b0, 32'h0,   16'd0);
    apply(0, 1'b1, add3,  1'b1, 1'b0, 1'b0, 32'h0,   16'd0);
    apply(0, 1'b1, sub4,  1'b1, 1'b0, 1'b1, 32'h8,   16'd0);
    apply(0, 1'b1, sub4,  1'b1, 1'b0, 1'b1, 32'h8,   16'd1);
    apply(0, 1'b1, sub4,  1'b1, 1'b0, 1'b0, 32'h0,   16'd2);
    apply(0, 1'b1, sub4,  1'b0, 1'b0, 1'b0, 32'h10,  16'd2);
    apply(0, 1'b1, add5,  1'b1, 1'b0, 1'b0, 32'h10,  16'd2);
    apply(0, 1'b1, addi5, 1'b1, 1'b0, 1'b0, 32'h20,  16'd2);
    apply(0, 1'b1, sw5,   1'b1, 1'b0, 1'b1, 32'h20,  16'd2);
    apply(0, 1'b1, sw5,   1'b1, 1'b0, 1'b1, 32'h20,  16'd3);
    apply(0, 1'b1, sw5,   1'b1, 1'b0, 1'b0, 32'h0,   16'd4);
    apply(0, 1'b1, add0,  1'b1, 1'b0, 1'b0, 32'h0,   16'd4);
    apply(0, 1'b1, or7,   1'b1, 1'b0, 1'b0, 32'h0,   16'd4);
    apply(0, 1'b1, or7,   1'b0, 1'b0, 1'b0, 32'h80,  16'd4);
    apply(0, 1'b1, or7,   1'b0, 1'b0, 1'b0, 32'h80,  16'd4);
    apply(0, 1'b1, add3,  1'b1, 1'b0, 1'b0, 32'h0,   16'd4);
    apply(0, 1'b1, beq3,  1'b1, 1'b0, 1'b1, 32'h8,   16'd4);
    apply(0, 1'b1, beq3,  1'b1, 1'b1, 1'b0, 32'h8,   16'd5);
    apply(0, 1'b1, beq3,  1'b1, 1'b0, 1'b0, 32'h0,   16'd5);
    apply(0, 1'b1, add3,  1'b1, 1'b0, 1'b0, 32'h0,   16'd5);
    apply(0, 1'b1, beq3,  1'b1, 1'b0, 1'b1, 32'h8,   16'd5);
    apply(0, 1'b0, beq3,  1'b1, 1'b0, 1'b1, 32'h8,   16'd6);
    apply(0, 1'b1, beq3,  1'b1, 1'b0, 1'b0, 32'h0,   16'd0);

    // ALU_LAT = 1, LOAD_LAT = 2: one load-use bubble, ALU results usable next cycle.
    apply(1, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'h0,   16'd0);
    apply(1, 1'b1, lw8,    1'b1, 1'b0, 1'b0, 32'h0,   16'd0);
    apply(1, 1'b1, add10,  1'b1, 1'b0, 1'b1, 32'h100, 16'd0);
    apply(1, 1'b1, add10,  1'b1, 1'b0, 1'b0, 32'h0,   16'd1);
    apply(1, 1'b1, addi11, 1'b1, 1'b0, 1'b0, 32'h0,   16'd1);
    apply(1, 1'b1, addi11, 1'b0, 1'b0, 1'b0, 32'h0,   16'd1);

    // ALU_LAT = 1, LOAD_LAT = 3: younger ALU write must not shorten the load.
    apply(2, 1'b0, 32'd0,  1'b0, 1'b0, 1'b0, 32'h0,   16'd0);
    apply(2, 1'b1, lw4,    1'b1, 1'b0, 1'b0, 32'h0,   16'd0);
    apply(2, 1'b1, add4,   1'b1, 1'b0, 1'b0, 32'h10,  16'd0);
    apply(2, 1'b1, add4,   1'b0, 1'b0, 1'b0, 32'h10,  16'd0);
    apply(2, 1'b1, add4,   1'b0, 1'b0, 1'b0, 32'h0,   16'd0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge Clk);
    if (exp_q.size() > 0) begin
      n_miss++;
      $display("FAIL drain: %0d vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
